// File: rtl/pattern_sequencer_if.sv
// Pixel fetch handshake between the DVI timing core (master) and a pixel source (slave).
// The timing core strobes fetch/frame_start and consumes the registered r/g/b.
interface pattern_sequencer_if;
    logic       fetch;
    logic       frame_start;
    logic [7:0] r_o;
    logic [7:0] g_o;
    logic [7:0] b_o;

    modport master (output fetch, output frame_start, input r_o, input g_o, input b_o);
    modport slave  (input fetch, input frame_start, output r_o, output g_o, output b_o);
endinterface

// File: rtl/pattern_sequencer.sv
// Test-pattern pixel source: tracks the active-pixel position, renders one of four
// patterns and switches patterns only on frame boundaries (buttons or auto-cycle timer).
module pattern_sequencer #(
    parameter int   X            = 800,
    parameter int   Y            = 600,
    parameter int   AUTO_FRAMES  = 120,
    parameter logic AUTO_DEFAULT = 1'b0
) (
    input  logic                clk_pixel,
    input  logic                reset,
    pattern_sequencer_if.slave  pix,
    input  logic                btn_next,
    input  logic                btn_prev,
    input  logic                btn_auto,
    output logic [1:0]          pattern,
    output logic                auto_en
);
    localparam int HW = $clog2(X);
    localparam int VW = $clog2(Y);
    localparam int FW = $clog2(AUTO_FRAMES + 1);
    localparam int AW = $clog2(X + 8);

    typedef enum logic [1:0] {
        PAT_RGB   = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_GRAD  = 2'd2,
        PAT_CHECK = 2'd3
    } pat_t;

    logic [HW-1:0] hcnt, cur_h, h_n;
    logic [VW-1:0] vcnt, cur_v, v_n;
    logic [1:0]    phase, cur_phase, phase_n;
    logic [2:0]    bar, cur_bar, bar_n;
    logic [AW-1:0] acc, cur_acc, acc_n, acc_sum;
    logic [FW-1:0] frame_cnt, fcnt_eff, fcnt_n;
    logic [1:0]    pending, pend_adj, pending_n, pattern_n;
    logic          next_q, prev_q, auto_q;
    logic          nx_edge, pv_edge, au_edge, auto_eff;
    logic [7:0]    h8, v8;
    logic [7:0]    r_n, g_n, b_n;

    always_comb begin
        nx_edge  = btn_next & ~next_q;
        pv_edge  = btn_prev & ~prev_q;
        au_edge  = btn_auto & ~auto_q;
        auto_eff = auto_en ^ au_edge;
        fcnt_eff = (nx_edge | pv_edge | au_edge) ? '0 : frame_cnt;

        pend_adj = pending;
        if (nx_edge && !pv_edge)
            pend_adj = pending + 2'd1;
        else if (pv_edge && !nx_edge)
            pend_adj = pending - 2'd1;

        // Button edges in the frame_start cycle land in pending before the commit.
        pending_n = pend_adj;
        pattern_n = pattern;
        fcnt_n    = fcnt_eff;
        if (pix.frame_start) begin
            if (auto_eff && fcnt_eff == FW'(AUTO_FRAMES - 1)) begin
                pending_n = pend_adj + 2'd1;
                pattern_n = pend_adj + 2'd1;
                fcnt_n    = '0;
            end else begin
                pattern_n = pend_adj;
                if (auto_eff)
                    fcnt_n = fcnt_eff + FW'(1);
            end
        end
    end

    // frame_start rewinds position state before the pixel for this cycle is rendered.
    always_comb begin
        cur_h     = pix.frame_start ? '0 : hcnt;
        cur_v     = pix.frame_start ? '0 : vcnt;
        cur_phase = pix.frame_start ? '0 : phase;
        cur_bar   = pix.frame_start ? '0 : bar;
        cur_acc   = pix.frame_start ? '0 : acc;

        h8 = 8'(cur_h);
        v8 = 8'(cur_v);
        r_n = '0;
        g_n = '0;
        b_n = '0;
        case (pat_t'(pattern_n))
            PAT_RGB: begin
                r_n = (cur_phase == 2'd0) ? '1 : '0;
                g_n = (cur_phase == 2'd1) ? '1 : '0;
                b_n = (cur_phase == 2'd2) ? '1 : '0;
            end
            PAT_BARS: begin
                r_n = cur_bar[2] ? '1 : '0;
                g_n = cur_bar[1] ? '1 : '0;
                b_n = cur_bar[0] ? '1 : '0;
            end
            PAT_GRAD: begin
                r_n = h8;
                g_n = v8;
                b_n = h8 ^ v8;
            end
            PAT_CHECK: begin
                r_n = (h8[5] ^ v8[5]) ? '1 : '0;
                g_n = r_n;
                b_n = r_n;
            end
            default: ;
        endcase

        // acc holds hcnt*8 - bar*X, so bar tracks floor(hcnt*8/X) without a divider.
        h_n     = cur_h;
        v_n     = cur_v;
        phase_n = cur_phase;
        bar_n   = cur_bar;
        acc_n   = cur_acc;
        acc_sum = cur_acc + AW'(8);
        if (pix.fetch) begin
            phase_n = (cur_phase == 2'd2) ? 2'd0 : cur_phase + 2'd1;
            if (cur_h == HW'(X - 1)) begin
                h_n   = '0;
                bar_n = '0;
                acc_n = '0;
                v_n   = (cur_v == VW'(Y - 1)) ? '0 : cur_v + VW'(1);
            end else begin
                h_n = cur_h + HW'(1);
                if (acc_sum >= AW'(X)) begin
                    acc_n = acc_sum - AW'(X);
                    bar_n = cur_bar + 3'd1;
                end else begin
                    acc_n = acc_sum;
                end
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            hcnt      <= '0;
            vcnt      <= '0;
            phase     <= '0;
            bar       <= '0;
            acc       <= '0;
            frame_cnt <= '0;
            pending   <= '0;
            pattern   <= '0;
            auto_en   <= AUTO_DEFAULT;
            next_q    <= btn_next;
            prev_q    <= btn_prev;
            auto_q    <= btn_auto;
            pix.r_o   <= '0;
            pix.g_o   <= '0;
            pix.b_o   <= '0;
        end else begin
            hcnt      <= h_n;
            vcnt      <= v_n;
            phase     <= phase_n;
            bar       <= bar_n;
            acc       <= acc_n;
            frame_cnt <= fcnt_n;
            pending   <= pending_n;
            pattern   <= pattern_n;
            auto_en   <= auto_eff;
            next_q    <= btn_next;
            prev_q    <= btn_prev;
            auto_q    <= btn_auto;
            if (pix.fetch) begin
                pix.r_o <= r_n;
                pix.g_o <= g_n;
                pix.b_o <= b_n;
            end
        end
    end
endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer (X=800, Y=600, AUTO_FRAMES=3).
module tb_pattern_sequencer;
    logic       clk_pixel = 1'b0;
    logic       reset;
    logic       btn_next, btn_prev, btn_auto;
    logic [1:0] pattern;
    logic       auto_en;
    int         n_checks = 0;
    int         n_errors = 0;

    pattern_sequencer_if pix ();

    pattern_sequencer #(
        .X(800), .Y(600), .AUTO_FRAMES(3), .AUTO_DEFAULT(1'b0)
    ) dut (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .pix       (pix.slave),
        .btn_next  (btn_next),
        .btn_prev  (btn_prev),
        .btn_auto  (btn_auto),
        .pattern   (pattern),
        .auto_en   (auto_en)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    function automatic logic [31:0] rgb();
        return {8'h00, pix.r_o, pix.g_o, pix.b_o};
    endfunction

    task automatic fetch_n(input int n);
        pix.fetch = 1'b1;
        for (int i = 0; i < n; i++) tick();
        pix.fetch = 1'b0;
    endtask

    task automatic frame();
        pix.frame_start = 1'b1;
        tick();
        pix.frame_start = 1'b0;
    endtask

    // which: 0 = next, 1 = prev, 2 = auto; press then release
    task automatic press(input int which);
        if (which == 0) btn_next = 1'b1;
        else if (which == 1) btn_prev = 1'b1;
        else btn_auto = 1'b1;
        tick();
        btn_next = 1'b0;
        btn_prev = 1'b0;
        btn_auto = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        btn_next = 1'b0; btn_prev = 1'b0; btn_auto = 1'b0;
        pix.fetch = 1'b0; pix.frame_start = 1'b0;
        tick(); tick();
        check("reset_rgb", rgb(), 32'h000000);
        check("reset_pattern", 32'(pattern), 32'd0);
        check("reset_auto", 32'(auto_en), 32'd0);
        reset = 1'b0;

        // RGB rotate
        frame();
        fetch_n(1); check("rot0", rgb(), 32'hFF0000);
        fetch_n(1); check("rot1", rgb(), 32'h00FF00);
        fetch_n(1); check("rot2", rgb(), 32'h0000FF);
        fetch_n(1); check("rot3", rgb(), 32'hFF0000);
        check("rot_pattern", 32'(pattern), 32'd0);

        // btn_next mid-frame waits for frame_start
        press(0);
        check("next_hold_pat", 32'(pattern), 32'd0);
        fetch_n(1); check("next_hold_rgb", rgb(), 32'h00FF00);
        frame();
        check("next_commit", 32'(pattern), 32'd1);
        fetch_n(99);
        fetch_n(1); check("bar_h99", rgb(), 32'h000000);
        fetch_n(1); check("bar_h100", rgb(), 32'h0000FF);
        fetch_n(698);
        fetch_n(1); check("bar_h799", rgb(), 32'hFFFFFF);
        fetch_n(1); check("bar_wrap", rgb(), 32'h000000);

        // two prev presses: 1 -> 0 -> 3
        press(1); press(1);
        check("prev_hold", 32'(pattern), 32'd1);
        frame();
        check("prev_commit", 32'(pattern), 32'd3);
        fetch_n(31);
        fetch_n(1); check("chk_31_0", rgb(), 32'h000000);
        fetch_n(1); check("chk_32_0", rgb(), 32'hFFFFFF);
        fetch_n(767 + 31 * 800 + 32);
        fetch_n(1); check("chk_32_32", rgb(), 32'h000000);

        // simultaneous next+prev: no change
        btn_next = 1'b1; btn_prev = 1'b1; tick();
        btn_next = 1'b0; btn_prev = 1'b0; tick();
        frame();
        check("both_edges", 32'(pattern), 32'd3);
        press(0); press(0); press(0);
        check("triple_hold", 32'(pattern), 32'd3);
        frame();
        check("triple_commit", 32'(pattern), 32'd2);

        // gradient
        fetch_n(1605);
        fetch_n(1); check("grad_5_2", rgb(), 32'h050207);
        frame();
        fetch_n(799);
        fetch_n(1); check("grad_799_0", rgb(), 32'h1F001F);
        fetch_n(1); check("grad_0_1", rgb(), 32'h000101);
        pix.frame_start = 1'b1; pix.fetch = 1'b1; tick();
        pix.frame_start = 1'b0; pix.fetch = 1'b0;
        check("fs_fetch_px", rgb(), 32'h000000);
        fetch_n(1); check("fs_fetch_next", rgb(), 32'h010001);

        // auto cycle every 3rd frame
        press(2);
        check("auto_on", 32'(auto_en), 32'd1);
        frame(); check("auto_f1", 32'(pattern), 32'd2);
        frame(); check("auto_f2", 32'(pattern), 32'd2);
        frame(); check("auto_f3", 32'(pattern), 32'd3);
        frame(); check("auto_f4", 32'(pattern), 32'd3);
        frame(); check("auto_f5", 32'(pattern), 32'd3);
        frame(); check("auto_f6", 32'(pattern), 32'd0);
        frame(); check("auto_f7", 32'(pattern), 32'd0);
        press(2);
        check("auto_off", 32'(auto_en), 32'd0);
        frame(); frame(); frame();
        check("auto_stopped", 32'(pattern), 32'd0);
        press(2);
        frame(); check("auto_g1", 32'(pattern), 32'd0);
        frame(); check("auto_g2", 32'(pattern), 32'd0);
        frame(); check("auto_g3", 32'(pattern), 32'd1);
        press(2);
        check("auto_off2", 32'(auto_en), 32'd0);

        // mid-line reset with pending ahead of pattern
        frame();
        fetch_n(7);
        press(0);
        reset = 1'b1; tick(); reset = 1'b0;
        check("rst_rgb", rgb(), 32'h000000);
        check("rst_pattern", 32'(pattern), 32'd0);
        frame();
        check("rst_pending", 32'(pattern), 32'd0);

        // button held through reset gives no edge
        btn_next = 1'b1;
        reset = 1'b1; tick(); reset = 1'b0; tick();
        frame();
        check("held_btn", 32'(pattern), 32'd0);
        btn_next = 1'b0; tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/pattern_sequencer.md
Name: pattern_sequencer

Overview:
- Pixel-source controller between the DVI timing core's fetch strobe and its r/g/b inputs.
- Tracks pixel position, generates one of four test patterns, and switches patterns only on frame boundaries.
- Pattern changes come from next/prev buttons or an auto-cycle frame timer.
- Replaces ad-hoc per-pixel colour toggling in the board top level.

Parameters:
- X, 800, active pixels per line.
- Y, 600, active lines per frame.
- AUTO_FRAMES, 120, frames per pattern in auto mode (>=1).
- AUTO_DEFAULT, 0, auto_en value after reset.

Ports:
- clk_pixel  in  1  pixel clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch  in  1  one-cycle strobe: the timing core consumes the current r/g/b and requests the next active pixel.
- frame_start  in  1  one-cycle pulse before the first fetch of a frame.
- btn_next  in  1  synchronised level; rising edge requests the next pattern.
- btn_prev  in  1  synchronised level; rising edge requests the previous pattern.
- btn_auto  in  1  synchronised level; rising edge toggles auto_en.
- r_o  out  8  red, registered.
- g_o  out  8  green, registered.
- b_o  out  8  blue, registered.
- pattern  out  2  active pattern index.
- auto_en  out  1  auto-cycle enabled.

Behaviour:
Reset (sync, active-high):
- r/g/b_o = 0; pattern = 0; pending = 0; hcnt = vcnt = 0; phase = 0; frame_cnt = 0; auto_en = AUTO_DEFAULT.
- Button edge-detect registers load the current input levels, so a button held through reset produces no edge.
- Reset asserted mid-frame aborts immediately; no pending change survives.

Position counters:
- hcnt is $clog2(X) bits; vcnt is $clog2(Y) bits.
- On fetch: hcnt++. At X-1, hcnt wraps to 0 and vcnt++. vcnt wraps Y-1 -> 0.
- frame_start forces hcnt = vcnt = 0 and phase = 0.
- frame_start and fetch in the same cycle: the pixel is computed at (0,0) with phase 0, then the counters become (1,0) and phase becomes 1.

Pixel output (latency 1):
- On a fetch cycle, r/g/b_o register the colour for the current (hcnt, vcnt, phase) under the active pattern.
- Outputs hold their value between fetches.
- Pattern colours:
  - 0 RGB rotate: phase 0 = FF,00,00; 1 = 00,FF,00; 2 = 00,00,FF. phase advances mod 3 per fetch.
  - 1 colour bars: bar = floor(hcnt*8/X), 3 bits. Each channel = FF if its bit is set (r=bar[2], g=bar[1], b=bar[0]), else 00. Implement with a bar counter and boundary compare, not a divider.
  - 2 gradient: r = hcnt[7:0]; g = vcnt[7:0]; b = hcnt[7:0] ^ vcnt[7:0].
  - 3 checker: all channels FF if hcnt[5] ^ vcnt[5], else 00.

Pattern scheduling (2-bit index arithmetic, wraps mod 4):
- Rising edge of btn_next: pending = pending + 1. Rising edge of btn_prev: pending = pending - 1.
- Both edges in the same cycle: no change.
- Multiple presses within one frame accumulate in pending.
- Any manual press clears frame_cnt.
- btn_auto edge toggles auto_en and clears frame_cnt.
- On frame_start:
  - If auto_en and frame_cnt == AUTO_FRAMES-1: pattern = pending = pending + 1 and frame_cnt = 0.
  - Otherwise: pattern = pending, and frame_cnt increments when auto_en.
- A button edge in the same cycle as frame_start is applied to pending before the commit, so it takes effect this frame.
- The pattern is never changed except on frame_start; the output stays stable within a frame.
- The pixel computed on a frame_start cycle already uses the newly committed pattern.

Test Plan:
- Reset, pattern 0, frame_start, then 4 fetches -> outputs after each fetch: FF0000, 00FF00, 0000FF, FF0000; pattern = 0.
- btn_next pulse mid-frame -> pattern stays 0 until the next frame_start, then 1. In pattern 1 with X=800: fetch at hcnt=99 -> 000000; hcnt=100 -> 0000FF; hcnt=799 -> FFFFFF.
- btn_prev from pattern 0 -> pattern 3 at the next frame. Checker: (31,0) -> 000000; (32,0) -> FFFFFF; (32,32) -> 000000.
- btn_next and btn_prev rising in the same cycle, then frame_start -> pattern unchanged. Three btn_next presses in one frame -> pattern advances by 3.
- AUTO_FRAMES=3 with auto_en set -> pattern advances on every 3rd frame_start (0,0,1,1,1,2...). btn_auto toggle -> advancing stops and frame_cnt = 0.
- Reset asserted mid-line with pending ≠ pattern -> next cycle all outputs 0, pattern 0. Pattern 2 at (5,2): fetch on X=800 wrap -> 05,02,07, and (799,0) is followed by (0,1).
